argo_3_stage: RTL and testbench
===============================

# argo_3_stage

Three-stage streaming pipeline that models three Argo go-routines connected by two channels. Stage 1 accepts words from an upstream producer and pushes them into channel FIFO 1. Stage 2 moves each word from FIFO 1 through variable X1 into channel FIFO 2. Stage 3 pops FIFO 2 into variable Z1 and presents it downstream. It is the reference target for the Argo-to-Verilog FIFO/control-bit templates, and uses an Avalon-style valid/ready handshake on both sides.

## Interface
- WIDTH, 32, data word width.
- FIFO_DEPTH, 4, entries per channel FIFO (power of two).
- ADDR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- ivalid  in  1  upstream word on datain is valid.
- oready  out  1  block can accept an upstream word this cycle.
- datain  in  WIDTH  upstream data.
- ovalid  out  1  dataout holds a valid word for downstream.
- iready  in  1  downstream accepts the word this cycle.
- dataout  out  WIDTH  downstream data.

## Operation
- Reset (rst=1 at a rising edge) sets the following to zero:
  - both FIFOs: read pointer, write pointer and count;
  - X1, Y1, Z1, dataout and ovalid;
  - stage 2 state to S2_READ and stage 3 state to S3_READ.
- Reset mid-operation discards all buffered words.
- oready is combinational: oready = !rst && (FIFO1 count < FIFO_DEPTH).
- Stage 1 (input loop):
  - On an edge with ivalid && oready, Y1 <= datain and datain is written into FIFO1.
  - ivalid while oready=0 is ignored; datain is not captured.
- Stage 2 (forward loop), two states:
  - S2_READ: if FIFO1 is non-empty, pop its head into X1 and go to S2_WRITE. Otherwise stay.
  - S2_WRITE: if FIFO2 is not full, push X1 into FIFO2 and go to S2_READ. Otherwise stay, holding X1.
- Stage 3 (output loop), two states:
  - S3_READ: if FIFO2 is non-empty, pop its head into Z1, set dataout <= head and ovalid <= 1, and go to S3_OUT.
  - S3_OUT: on an edge with iready=1, the word is transferred.
    - If FIFO2 is non-empty at that edge, pop the next word into Z1/dataout, keep ovalid=1 and stay in S3_OUT.
    - Otherwise set ovalid <= 0 and go to S3_READ.
  - With iready=0, dataout and ovalid hold.
- FIFOs:
  - Circular register arrays with first-word-fall-through reads: the head is combinationally visible.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge leaves the count unchanged.
  - Pushing when full and popping when empty never occur; the stage guards prevent them.
- Data passes unmodified; word order is preserved end to end.
- Buffer capacity is 10 words: FIFO1 4, X1 1, FIFO2 4, Z1 1.

## Timing
- Accepting edge E0: the word enters FIFO1.
- E1: stage 2 pops the word into X1.
- E2: stage 2 pushes it into FIFO2.
- E3: stage 3 loads it into dataout, and ovalid=1 is visible after E3.
- Input-to-output latency is 3 cycles.
- Stage 2 throughput is one word per 2 cycles, so sustained input faster than that fills FIFO1 and drops oready.
- The first cycle after reset deasserts has oready=1 and ovalid=0.

## Test plan
- Reset: hold rst=1 for one edge, then release.
  - Required: ovalid=0 and dataout=0.
  - Required: oready=0 while rst=1 and oready=1 after release.
- Single word: with iready=1, drive datain=0x25 and ivalid=1 for one edge E0.
  - Required: ovalid=1 and dataout=0x25 after E3, then ovalid=0 after E4.
- Back-to-back words: drive 0x25 then 0x26 on consecutive edges, with iready=1.
  - Required: 0x25 then 0x26 emerge in order, each exactly once, with the second 2 cycles after the first.
- Backpressure: hold iready=0 and present words 1..12 continuously.
  - Required: exactly 10 words are accepted, then oready=0.
  - Required: dataout stays at 1 with ovalid=1.
  - Then raise iready=1. Required: words 1..10 emerge in order and oready returns to 1.
- ivalid=1 with datain=0x77 while oready=0 (FIFO1 full).
  - Required: the word is dropped and never appears on dataout.
- Assert rst with 5 words buffered.
  - Required: after reset, ovalid=0 and oready=1, and no stale word appears within 10 cycles.

Source files
------------

// File: rtl/argo_3_stage.sv
// argo_3_stage: three go-routines joined by two channel FIFOs.
// Stage 1 feeds FIFO1, stage 2 moves FIFO1 -> X1 -> FIFO2, stage 3 drains FIFO2.
// Ports: clk, rst (sync, active-high)
//   upstream   : ivalid, oready, datain[WIDTH]
//   downstream : ovalid, iready, dataout[WIDTH]
module argo_3_stage #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid,
    output logic             oready,
    input  logic [WIDTH-1:0] datain,
    output logic             ovalid,
    input  logic             iready,
    output logic [WIDTH-1:0] dataout
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic {S2_READ, S2_WRITE} s2_e;
    typedef enum logic {S3_READ, S3_OUT} s3_e;

    logic [WIDTH-1:0]      mem1_q [FIFO_DEPTH];
    logic [WIDTH-1:0]      mem2_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wp1_q, rp1_q, wp2_q, rp2_q;
    logic [CW-1:0]         cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [WIDTH-1:0]      x1_q, x1_d, y1_q, y1_d, z1_q, z1_d;
    logic                  ovalid_q, ovalid_d;
    s2_e                   s2_q, s2_d;
    s3_e                   s3_q, s3_d;

    logic push1, pop1, push2, pop2;

    assign oready  = !rst && (cnt1_q != FULL);
    assign ovalid  = ovalid_q;
    assign dataout = z1_q;

    always_comb begin
        push1    = ivalid && oready;
        pop1     = (s2_q == S2_READ) && (cnt1_q != '0);
        push2    = (s2_q == S2_WRITE) && (cnt2_q != FULL);
        // Stage 3 pops on first load, or when the held word is taken
        // and another one is already waiting.
        pop2     = (cnt2_q != '0) && ((s3_q == S3_READ) || iready);

        y1_d     = push1 ? datain : y1_q;
        x1_d     = x1_q;
        z1_d     = z1_q;
        ovalid_d = ovalid_q;
        s2_d     = s2_q;
        s3_d     = s3_q;

        unique case (s2_q)
            S2_READ: begin
                if (pop1) begin
                    x1_d = mem1_q[rp1_q];
                    s2_d = S2_WRITE;
                end
            end
            S2_WRITE: begin
                if (push2) s2_d = S2_READ;
            end
        endcase

        unique case (s3_q)
            S3_READ: begin
                if (pop2) begin
                    z1_d     = mem2_q[rp2_q];
                    ovalid_d = 1'b1;
                    s3_d     = S3_OUT;
                end
            end
            S3_OUT: begin
                if (iready) begin
                    if (pop2) begin
                        z1_d = mem2_q[rp2_q];
                    end else begin
                        ovalid_d = 1'b0;
                        s3_d     = S3_READ;
                    end
                end
            end
        endcase

        cnt1_d = cnt1_q;
        if (push1 && !pop1) cnt1_d = cnt1_q + 1'b1;
        if (!push1 && pop1) cnt1_d = cnt1_q - 1'b1;

        cnt2_d = cnt2_q;
        if (push2 && !pop2) cnt2_d = cnt2_q + 1'b1;
        if (!push2 && pop2) cnt2_d = cnt2_q - 1'b1;
    end

    // Storage arrays carry no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (push1) mem1_q[wp1_q] <= y1_d;
        if (push2 && !rst) mem2_q[wp2_q] <= x1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp1_q    <= '0;
            rp1_q    <= '0;
            cnt1_q   <= '0;
            wp2_q    <= '0;
            rp2_q    <= '0;
            cnt2_q   <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            z1_q     <= '0;
            ovalid_q <= 1'b0;
            s2_q     <= S2_READ;
            s3_q     <= S3_READ;
        end else begin
            if (push1) wp1_q <= wp1_q + 1'b1;
            if (pop1)  rp1_q <= rp1_q + 1'b1;
            if (push2) wp2_q <= wp2_q + 1'b1;
            if (pop2)  rp2_q <= rp2_q + 1'b1;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            z1_q     <= z1_d;
            ovalid_q <= ovalid_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
        end
    end

endmodule

// File: tb/tb_argo_3_stage.sv
// tb_argo_3_stage: vector table for timing, scoreboard for data order,
// plus backpressure, drop and mid-stream reset sequences.
module tb_argo_3_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ivalid = 1'b0;
    logic        oready;
    logic [31:0] datain = '0;
    logic        ovalid;
    logic        iready = 1'b0;
    logic [31:0] dataout;

    always #5 clk = ~clk;

    argo_3_stage dut (
        .clk     (clk),
        .rst     (rst),
        .ivalid  (ivalid),
        .oready  (oready),
        .datain  (datain),
        .ovalid  (ovalid),
        .iready  (iready),
        .dataout (dataout)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic        ir;
        logic [31:0] d;
        logic        e_ordy;
        logic        e_oval;
        logic [31:0] e_dout;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          accepted = 0;
    int          outs     = 0;
    logic [31:0] sb[$];
    vec_t        tbl[16];

    function automatic vec_t mk(logic r, logic v, logic ir, logic [31:0] d,
                                logic eo, logic ev, logic [31:0] ed);
        vec_t t;
        t.r = r; t.v = v; t.ir = ir; t.d = d;
        t.e_ordy = eo; t.e_oval = ev; t.e_dout = ed;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, log handshakes just before the rising
    // edge, then leave outputs settled 1ns after it for checking.
    task automatic step(input logic r, input logic v, input logic ir,
                        input logic [31:0] d);
        logic [31:0] exp;
        @(negedge clk);
        rst = r; ivalid = v; iready = ir; datain = d;
        #1;
        if (r) begin
            sb.delete();
        end else begin
            if (v && oready) begin
                sb.push_back(d);
                accepted++;
            end
            if (ovalid && ir) begin
                outs++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got %h want none", dataout);
                end else begin
                    exp = sb.pop_front();
                    check("sb_data", dataout, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int w;

        tbl[0]  = mk(1, 0, 1, 32'h00, 0, 0, 32'h00);
        tbl[1]  = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);
        tbl[2]  = mk(0, 1, 1, 32'h25, 1, 0, 32'h00);
        tbl[3]  = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);
        tbl[4]  = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);
        tbl[5]  = mk(0, 0, 1, 32'h00, 1, 1, 32'h25);
        tbl[6]  = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);
        tbl[7]  = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);
        tbl[8]  = mk(0, 1, 1, 32'h25, 1, 0, 32'h00);
        tbl[9]  = mk(0, 1, 1, 32'h26, 1, 0, 32'h00);
        tbl[10] = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);
        tbl[11] = mk(0, 0, 1, 32'h00, 1, 1, 32'h25);
        tbl[12] = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);
        tbl[13] = mk(0, 0, 1, 32'h00, 1, 1, 32'h26);
        tbl[14] = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);
        tbl[15] = mk(0, 0, 1, 32'h00, 1, 0, 32'h00);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].ir, tbl[i].d);
            check($sformatf("v%0d_oready", i), 32'(oready), 32'(tbl[i].e_ordy));
            check($sformatf("v%0d_ovalid", i), 32'(ovalid), 32'(tbl[i].e_oval));
            if (tbl[i].e_oval)
                check($sformatf("v%0d_dataout", i), dataout, tbl[i].e_dout);
        end
        check("single_b2b_outs", outs, 3);

        // Backpressure: fill all ten slots with iready low.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        accepted = 0;
        w = 1;
        for (int c = 0; c < 80; c++) begin
            base = accepted;
            step(0, 1, 0, w);
            if (accepted != base && w < 12) w++;
        end
        check("bp_accepted", accepted, 10);
        check("bp_oready", 32'(oready), 0);
        check("bp_ovalid", 32'(ovalid), 1);
        check("bp_dataout", dataout, 1);

        for (int c = 0; c < 3; c++) begin
            step(0, 1, 0, 32'h77);
            check("drop_oready", 32'(oready), 0);
        end
        check("drop_accepted", accepted, 10);

        outs = 0;
        for (int c = 0; c < 80 && (sb.size() != 0 || ovalid); c++)
            step(0, 0, 1, 0);
        check("drain_outs", outs, 10);
        check("drain_sb_left", sb.size(), 0);
        check("drain_oready", 32'(oready), 1);
        check("drain_ovalid", 32'(ovalid), 0);

        // Mid-stream reset with five words buffered.
        base = accepted;
        for (int k = 0; k < 5; k++)
            step(0, 1, 0, 32'h40 + k);
        check("rst_buffered", accepted - base, 5);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check("rst_ovalid", 32'(ovalid), 0);
        check("rst_oready", 32'(oready), 1);
        outs = 0;
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 1, 0);
            check("rst_no_stale", 32'(ovalid), 0);
        end
        check("rst_outs", outs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
